fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the opcode decoder.
- Holds the PC and fetches from instruction memory over a req/ack handshake.
- Writes the IF/ID pipeline register; `opcode` (`ifid_instr[31:26]`) feeds the control decoder.
- Handles decode-stage stalls and branch/jump redirects, including a redirect that arrives while a fetch is still outstanding.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_stage_ifid_reg.sv | 37 +++
 rtl/fetch_stage.sv | 156 +++++++++++++++
 tb/tb_fetch_stage.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: flush beats load, load beats hold;
// with none of them asserted the register bubbles (valid drops, data kept).
module ifid_reg
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              hold,
    input  logic              flush,
    input  logic [31:0]       instr_d,
    input  logic [ADDR_W-1:0] pc4_d,
    output logic              valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc4
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            pc4   <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
        end else if (load) begin
            valid <= 1'b1;
            instr <= instr_d;
            pc4   <= pc4_d;
        end else if (!hold) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem req/ack handshake, skid for stalls,
// and redirect handling including redirects that land mid-fetch.
//
//   state | meaning
//   FETCH | request outstanding at pc; ack delivers into IF/ID or skid
//   HOLD  | acked word parked in skid while decode stalls; no request
//   DROP  | redirected mid-fetch; wait for ack, discard it, go to pend_pc
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              ifid_valid,
    output logic [31:0]       ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc4,
    output logic [5:0]        opcode
);

    fetch_state_e      state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [ADDR_W-1:0] pend_pc, pend_pc_nxt;
    logic [31:0]       skid_instr, skid_instr_nxt;
    logic [ADDR_W-1:0] skid_pc4, skid_pc4_nxt;

    logic              ifid_load, ifid_hold, ifid_flush;
    logic [31:0]       ifid_instr_d;
    logic [ADDR_W-1:0] ifid_pc4_d;

    logic              ack_ok;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] target;

    assign imem_req  = ((state == FETCH) || (state == DROP)) && !reset;
    assign imem_addr = pc;
    // an ack outside an active request is a protocol violation and is ignored
    assign ack_ok    = imem_ack && imem_req;
    assign pc_plus4  = pc + ADDR_W'(4);
    assign target    = {redirect_pc[ADDR_W-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            pend_pc    <= '0;
            skid_instr <= NOP_INSTR;
            skid_pc4   <= '0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            pend_pc    <= pend_pc_nxt;
            skid_instr <= skid_instr_nxt;
            skid_pc4   <= skid_pc4_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        pend_pc_nxt    = pend_pc;
        skid_instr_nxt = skid_instr;
        skid_pc4_nxt   = skid_pc4;
        ifid_load      = 1'b0;
        ifid_hold      = 1'b0;
        ifid_flush     = 1'b0;
        ifid_instr_d   = imem_rdata;
        ifid_pc4_d     = pc_plus4;

        if (redirect) begin
            ifid_flush = 1'b1;
            case (state)
                FETCH: begin
                    if (ack_ok) begin
                        pc_nxt = target;
                    end else begin
                        pend_pc_nxt = target;
                        state_nxt   = DROP;
                    end
                end
                HOLD: begin
                    pc_nxt    = target;
                    state_nxt = FETCH;
                end
                DROP: begin
                    if (ack_ok) begin
                        pc_nxt    = target;
                        state_nxt = FETCH;
                    end else begin
                        pend_pc_nxt = target;
                    end
                end
                default: state_nxt = FETCH;
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (ack_ok && stall) begin
                        skid_instr_nxt = imem_rdata;
                        skid_pc4_nxt   = pc_plus4;
                        ifid_hold      = 1'b1;
                        state_nxt      = HOLD;
                    end else if (ack_ok) begin
                        ifid_load = 1'b1;
                        pc_nxt    = pc_plus4;
                    end else begin
                        ifid_hold = stall;
                    end
                end
                HOLD: begin
                    if (stall) begin
                        ifid_hold = 1'b1;
                    end else begin
                        ifid_load    = 1'b1;
                        ifid_instr_d = skid_instr;
                        ifid_pc4_d   = skid_pc4;
                        pc_nxt       = pc_plus4;
                        state_nxt    = FETCH;
                    end
                end
                DROP: begin
                    ifid_hold = stall;
                    if (ack_ok) begin
                        pc_nxt    = pend_pc;
                        state_nxt = FETCH;
                    end
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

    ifid_reg #(.ADDR_W(ADDR_W)) u_ifid (
        .clk     (clk),
        .reset   (reset),
        .load    (ifid_load),
        .hold    (ifid_hold),
        .flush   (ifid_flush),
        .instr_d (ifid_instr_d),
        .pc4_d   (ifid_pc4_d),
        .valid   (ifid_valid),
        .instr   (ifid_instr),
        .pc4     (ifid_pc4)
    );

    assign opcode = ifid_instr[31:26];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random
// traffic against a behavioural model of the fetch stage.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic [5:0]  opcode;

    int total = 0;
    int bad   = 0;

    // behavioural model: where fetching is, what is parked, what IF/ID shows
    logic [31:0] m_pc = 32'h0;
    logic        m_parked = 1'b0;
    logic [31:0] m_park_instr = 32'h0;
    logic [31:0] m_park_pc4 = 32'h0;
    logic        m_dropping = 1'b0;
    logic [31:0] m_pend = 32'h0;
    logic        m_valid = 1'b0;
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_pc4 = 32'h0;

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ifid_valid  (ifid_valid),
        .ifid_instr  (ifid_instr),
        .ifid_pc4    (ifid_pc4),
        .opcode      (opcode)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    // apply one cycle of inputs, advance the model, land 1 ns after the edge
    task automatic tick(input logic r, input logic s, input logic rd,
                        input logic [31:0] rpc, input logic a);
        logic        took;
        logic [31:0] word;
        logic [31:0] tgt;
        reset       = r;
        stall       = s;
        redirect    = rd;
        redirect_pc = rpc;
        imem_ack    = a;
        imem_rdata  = mem_word(imem_addr);
        took = a && !r && !m_parked;
        word = mem_word(m_pc);
        tgt  = rpc & 32'hFFFF_FFFC;
        if (r) begin
            m_pc = 32'h0; m_parked = 1'b0; m_dropping = 1'b0; m_pend = 32'h0;
            m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0;
        end else if (rd) begin
            m_valid = 1'b0;
            m_instr = 32'h0;
            if (m_parked) begin
                m_parked = 1'b0;
                m_pc = tgt;
            end else if (took) begin
                m_dropping = 1'b0;
                m_pc = tgt;
            end else begin
                m_dropping = 1'b1;
                m_pend = tgt;
            end
        end else if (m_parked) begin
            if (!s) begin
                m_valid = 1'b1; m_instr = m_park_instr; m_pc4 = m_park_pc4;
                m_pc = m_pc + 32'd4;
                m_parked = 1'b0;
            end
        end else if (took && !m_dropping) begin
            if (s) begin
                m_parked = 1'b1; m_park_instr = word; m_park_pc4 = m_pc + 32'd4;
            end else begin
                m_valid = 1'b1; m_instr = word; m_pc4 = m_pc + 32'd4;
                m_pc = m_pc + 32'd4;
            end
        end else begin
            if (took) begin
                m_pc = m_pend;
                m_dropping = 1'b0;
            end
            if (!s) m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ifid_valid); end
        total++; if (ifid_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", ifid_instr); end
        total++; if (ifid_pc4 !== 32'h0) begin bad++; $display("FAIL reset_pc4 got=%h exp=0", ifid_pc4); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] w;
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            w = mem_word(32'(4 * (k - 1)));
            total++; if (ifid_valid !== 1'b1) begin bad++; $display("FAIL zw_valid k=%0d got=%b exp=1", k, ifid_valid); end
            total++; if (ifid_pc4 !== 32'(4 * k)) begin bad++; $display("FAIL zw_pc4 k=%0d got=%h exp=%h", k, ifid_pc4, 32'(4 * k)); end
            total++; if (ifid_instr !== w) begin bad++; $display("FAIL zw_instr k=%0d got=%h exp=%h", k, ifid_instr, w); end
            total++; if (opcode !== w[31:26]) begin bad++; $display("FAIL zw_opcode k=%0d got=%h exp=%h", k, opcode, w[31:26]); end
        end
    endtask

    task automatic test_latency();
        logic [31:0] a;
        do_reset();
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        a = 32'h4;
        for (int n = 0; n < 3; n++) begin
            for (int w = 0; w < 2; w++) begin
                tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
                total++; if (imem_addr !== a) begin bad++; $display("FAIL lat_addr got=%h exp=%h", imem_addr, a); end
                total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL lat_bubble got=%b exp=0", ifid_valid); end
                total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL lat_req got=%b exp=1", imem_req); end
            end
            tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            total++; if (ifid_valid !== 1'b1) begin bad++; $display("FAIL lat_valid got=%b exp=1", ifid_valid); end
            total++; if (ifid_pc4 !== a + 32'd4) begin bad++; $display("FAIL lat_pc4 got=%h exp=%h", ifid_pc4, a + 32'd4); end
            total++; if (ifid_instr !== mem_word(a)) begin bad++; $display("FAIL lat_instr got=%h exp=%h", ifid_instr, mem_word(a)); end
            a = a + 32'd4;
        end
    endtask

    task automatic test_stall_skid();
        do_reset();
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        total++; if (ifid_valid !== 1'b1 || ifid_pc4 !== 32'h4) begin bad++; $display("FAIL stall_hold got=%b/%h exp=1/4", ifid_valid, ifid_pc4); end
        tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL hold_req got=%b exp=0", imem_req); end
            total++; if (ifid_pc4 !== 32'h4 || ifid_instr !== mem_word(32'h0)) begin bad++; $display("FAIL hold_ifid got=%h/%h exp=4/%h", ifid_pc4, ifid_instr, mem_word(32'h0)); end
        end
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        total++; if (ifid_valid !== 1'b1 || ifid_pc4 !== 32'h8) begin bad++; $display("FAIL skid_pc4 got=%b/%h exp=1/8", ifid_valid, ifid_pc4); end
        total++; if (ifid_instr !== mem_word(32'h4)) begin bad++; $display("FAIL skid_instr got=%h exp=%h", ifid_instr, mem_word(32'h4)); end
        total++; if (imem_addr !== 32'h8 || imem_req !== 1'b1) begin bad++; $display("FAIL skid_next got=%h/%b exp=8/1", imem_addr, imem_req); end
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        total++; if (ifid_pc4 !== 32'hC || ifid_instr !== mem_word(32'h8)) begin bad++; $display("FAIL skid_after got=%h/%h exp=c/%h", ifid_pc4, ifid_instr, mem_word(32'h8)); end
    endtask

    task automatic test_redirect_ack();
        do_reset();
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 32'h100, 1'b1);
        total++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin bad++; $display("FAIL rda_flush got=%b/%h exp=0/0", ifid_valid, ifid_instr); end
        total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL rda_addr got=%h exp=100", imem_addr); end
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        total++; if (ifid_pc4 !== 32'h104 || ifid_instr !== mem_word(32'h100)) begin bad++; $display("FAIL rda_next got=%h/%h exp=104/%h", ifid_pc4, ifid_instr, mem_word(32'h100)); end
    endtask

    task automatic test_redirect_drop();
        do_reset();
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
        total++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin bad++; $display("FAIL drop_old_addr got=%h/%b exp=4/1", imem_addr, imem_req); end
        total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL drop_flush got=%b exp=0", ifid_valid); end
        tick(1'b0, 1'b0, 1'b1, 32'h302, 1'b0);
        total++; if (imem_addr !== 32'h4) begin bad++; $display("FAIL drop_stable got=%h exp=4", imem_addr); end
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        total++; if (ifid_valid !== 1'b0 || imem_addr !== 32'h300) begin bad++; $display("FAIL drop_discard got=%b/%h exp=0/300", ifid_valid, imem_addr); end
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        total++; if (ifid_pc4 !== 32'h304 || ifid_instr !== mem_word(32'h300)) begin bad++; $display("FAIL drop_next got=%h/%h exp=304/%h", ifid_pc4, ifid_instr, mem_word(32'h300)); end
    endtask

    task automatic test_wrap();
        tick(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr got=%h exp=fffffffc", imem_addr); end
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        total++; if (ifid_pc4 !== 32'h0 || ifid_instr !== mem_word(32'hFFFF_FFFC)) begin bad++; $display("FAIL wrap_pc4 got=%h/%h exp=0/%h", ifid_pc4, ifid_instr, mem_word(32'hFFFF_FFFC)); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_next got=%h exp=0", imem_addr); end
    endtask

    task automatic test_redirect_stall();
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 32'h40, 1'b1);
        total++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin bad++; $display("FAIL rs_flush got=%b/%h exp=0/0", ifid_valid, ifid_instr); end
        total++; if (imem_addr !== 32'h40 || imem_req !== 1'b1) begin bad++; $display("FAIL rs_addr got=%h/%b exp=40/1", imem_addr, imem_req); end
        tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 32'h80, 1'b0);
        total++; if (imem_addr !== 32'h80 || imem_req !== 1'b1 || ifid_valid !== 1'b0) begin bad++; $display("FAIL rs_hold got=%h/%b/%b exp=80/1/0", imem_addr, imem_req, ifid_valid); end
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        total++; if (ifid_pc4 !== 32'h84 || ifid_valid !== 1'b1) begin bad++; $display("FAIL rs_next got=%h/%b exp=84/1", ifid_pc4, ifid_valid); end
    endtask

    task automatic test_reset_mid();
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b0, 1'b0, 32'h0, i == 1);
            total++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_pc4 !== 32'h0) begin bad++; $display("FAIL rm_ifid got=%b/%h/%h exp=0/0/0", ifid_valid, ifid_instr, ifid_pc4); end
            total++; if (imem_addr !== 32'h0 || imem_req !== 1'b0) begin bad++; $display("FAIL rm_req got=%h/%b exp=0/0", imem_addr, imem_req); end
        end
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || ifid_valid !== 1'b0) begin bad++; $display("FAIL rm_restart got=%b/%h/%b exp=1/0/0", imem_req, imem_addr, ifid_valid); end
    endtask

    task automatic test_random();
        logic r, s, rd, a, req_exp;
        logic [31:0] rpc;
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(0, 99) == 0);
            s   = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 11) == 0);
            rpc = $urandom;
            if (imem_req) a = ($urandom_range(0, 2) != 0);
            else          a = ($urandom_range(0, 15) == 0);
            tick(r, s, rd, rpc, a);
            req_exp = !reset && !m_parked;
            total++; if (ifid_valid !== m_valid) begin bad++; $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, ifid_valid, m_valid); end
            total++; if (ifid_instr !== m_instr) begin bad++; $display("FAIL rnd_instr i=%0d got=%h exp=%h", i, ifid_instr, m_instr); end
            total++; if (ifid_pc4 !== m_pc4) begin bad++; $display("FAIL rnd_pc4 i=%0d got=%h exp=%h", i, ifid_pc4, m_pc4); end
            total++; if (opcode !== m_instr[31:26]) begin bad++; $display("FAIL rnd_opcode i=%0d got=%h exp=%h", i, opcode, m_instr[31:26]); end
            total++; if (imem_addr !== m_pc) begin bad++; $display("FAIL rnd_addr i=%0d got=%h exp=%h", i, imem_addr, m_pc); end
            total++; if (imem_req !== req_exp) begin bad++; $display("FAIL rnd_req i=%0d got=%b exp=%b", i, imem_req, req_exp); end
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_latency();
        test_stall_skid();
        test_redirect_ack();
        test_redirect_drop();
        test_wrap();
        test_redirect_stall();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
